// File: rtl/inst_decode_stage.sv
// inst_decode_stage: registered, handshaked instruction-decode stage.
// Wraps the combinational Inst_Decoder, queues decoded entries in an elastic
// FIFO of DEPTH entries, and inserts one bubble for a load-use hazard.
// Optional feature macro: DEC_ILLEGAL_TRAP_EN (flags undefined encodings,
// suppresses their register/memory writes and keeps them from arming the
// hazard tracker). Without it out_illegal is tied to 0.

// Inst_Decoder: combinational MIPS-subset decoder.
// Af: 0 add,1 addu,2 sub,3 subu,4 and,5 or,6 xor,7 nor,8 slt,9 sltu,A lui
// Bf: 1 beq,2 bne,3 blez,4 bgtz,8 bltz,9 bgez
// GP_MUX_SEL: 0 alu,1 memory,2 link pc,3 shifter
// Shift_type: 1 sll,2 srl,3 sra,5 sllv,6 srlv,7 srav
// PC_MUX_Select: 0 pc+4,1 branch,2 jump target,3 register
module Inst_Decoder (
    input  logic [31:0] instr,
    output logic [3:0]  Af,
    output logic [3:0]  Bf,
    output logic        I,
    output logic        ALU_MUX_SEL,
    output logic        GP_WE,
    output logic        DM_WE,
    output logic [4:0]  Cad,
    output logic [1:0]  GP_MUX_SEL,
    output logic [2:0]  Shift_type,
    output logic [1:0]  PC_MUX_Select
);
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign funct       = instr[5:0];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    // Field decode; undefined encodings leave every output at zero.
    always_comb begin
        Af            = 4'h0;
        Bf            = 4'h0;
        I             = 1'b0;
        ALU_MUX_SEL   = 1'b0;
        GP_WE         = 1'b0;
        DM_WE         = 1'b0;
        Cad           = 5'd0;
        GP_MUX_SEL    = 2'd0;
        Shift_type    = 3'd0;
        PC_MUX_Select = 2'd0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        GP_WE      = 1'b1;
                        Cad        = rd;
                        GP_MUX_SEL = 2'd3;
                        case (funct)
                            6'h00:   Shift_type = 3'd1;
                            6'h02:   Shift_type = 3'd2;
                            6'h03:   Shift_type = 3'd3;
                            6'h04:   Shift_type = 3'd5;
                            6'h06:   Shift_type = 3'd6;
                            default: Shift_type = 3'd7;
                        endcase
                    end
                    6'h08: PC_MUX_Select = 2'd3;
                    6'h09: begin
                        PC_MUX_Select = 2'd3;
                        GP_WE         = 1'b1;
                        Cad           = rd;
                        GP_MUX_SEL    = 2'd2;
                    end
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: begin
                        Af    = {1'b0, funct[2:0]};
                        GP_WE = 1'b1;
                        Cad   = rd;
                    end
                    6'h2A, 6'h2B: begin
                        Af    = {3'b100, funct[0]};
                        GP_WE = 1'b1;
                        Cad   = rd;
                    end
                    default: ;
                endcase
            end
            6'h01: begin
                if (rt == 5'd0 || rt == 5'd1) begin
                    Bf            = {3'b100, rt[0]};
                    PC_MUX_Select = 2'd1;
                end
            end
            6'h02: PC_MUX_Select = 2'd2;
            6'h03: begin
                PC_MUX_Select = 2'd2;
                GP_WE         = 1'b1;
                Cad           = 5'd31;
                GP_MUX_SEL    = 2'd2;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                Af            = 4'h2;
                Bf            = {1'b0, opcode[2:0]} - 4'h3;
                PC_MUX_Select = 2'd1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                I           = 1'b1;
                ALU_MUX_SEL = 1'b1;
                GP_WE       = 1'b1;
                Cad         = rt;
                case (opcode[2:0])
                    3'd0:    Af = 4'h0;
                    3'd1:    Af = 4'h1;
                    3'd2:    Af = 4'h8;
                    3'd3:    Af = 4'h9;
                    3'd4:    Af = 4'h4;
                    3'd5:    Af = 4'h5;
                    3'd6:    Af = 4'h6;
                    default: Af = 4'hA;
                endcase
            end
            6'h23: begin
                Af          = 4'h1;
                I           = 1'b1;
                ALU_MUX_SEL = 1'b1;
                GP_WE       = 1'b1;
                Cad         = rt;
                GP_MUX_SEL  = 2'd1;
            end
            6'h2B: begin
                Af          = 4'h1;
                I           = 1'b1;
                ALU_MUX_SEL = 1'b1;
                DM_WE       = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module inst_decode_stage #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_Af,
    output logic [3:0]       out_Bf,
    output logic             out_I,
    output logic             out_ALU_MUX_SEL,
    output logic             out_GP_WE,
    output logic             out_DM_WE,
    output logic [4:0]       out_Cad,
    output logic [1:0]       out_GP_MUX_SEL,
    output logic [2:0]       out_Shift_type,
    output logic [1:0]       out_PC_MUX_Select,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [31:0]      out_imm,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]      af;
        logic [3:0]      bf;
        logic            imm_sel;
        logic            alu_mux_sel;
        logic            gp_we;
        logic            dm_we;
        logic [4:0]      cad;
        logic [1:0]      gp_mux_sel;
        logic [2:0]      shift_type;
        logic [1:0]      pc_mux_select;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         wr_entry;
    entry_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           armed;
    logic [4:0]     ld_rd;
    logic           stall_done;
    logic           stall_now;
    logic           push;
    logic           pop;
    logic           illegal;
    logic           is_jump;
    logic           src_match;
    logic           is_lw;
    logic [5:0]     opcode;

    logic [3:0]     dec_af;
    logic [3:0]     dec_bf;
    logic           dec_i;
    logic           dec_alu_mux_sel;
    logic           dec_gp_we;
    logic           dec_dm_we;
    logic [4:0]     dec_cad;
    logic [1:0]     dec_gp_mux_sel;
    logic [2:0]     dec_shift_type;
    logic [1:0]     dec_pc_mux_select;

    Inst_Decoder u_dec (
        .instr         (in_instr),
        .Af            (dec_af),
        .Bf            (dec_bf),
        .I             (dec_i),
        .ALU_MUX_SEL   (dec_alu_mux_sel),
        .GP_WE         (dec_gp_we),
        .DM_WE         (dec_dm_we),
        .Cad           (dec_cad),
        .GP_MUX_SEL    (dec_gp_mux_sel),
        .Shift_type    (dec_shift_type),
        .PC_MUX_Select (dec_pc_mux_select)
    );

    assign opcode = in_instr[31:26];

`ifdef DEC_ILLEGAL_TRAP_EN
    // Legal-set check: anything outside the supported subset is flagged.
    always_comb begin
        illegal = 1'b1;
        case (opcode)
            6'h00: begin
                case (in_instr[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: illegal = 1'b0;
                    default:      illegal = 1'b1;
                endcase
            end
            6'h01: illegal = !(in_instr[20:16] == 5'd0 || in_instr[20:16] == 5'd1);
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h2B: illegal = 1'b0;
            default:      illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // Entry assembled from the decoder; illegal encodings never write state.
    always_comb begin
        wr_entry               = '0;
        wr_entry.af            = dec_af;
        wr_entry.bf            = dec_bf;
        wr_entry.imm_sel       = dec_i;
        wr_entry.alu_mux_sel   = dec_alu_mux_sel;
        wr_entry.gp_we         = dec_gp_we & ~illegal;
        wr_entry.dm_we         = dec_dm_we & ~illegal;
        wr_entry.cad           = dec_cad;
        wr_entry.gp_mux_sel    = dec_gp_mux_sel;
        wr_entry.shift_type    = dec_shift_type;
        wr_entry.pc_mux_select = dec_pc_mux_select;
        wr_entry.rs            = in_instr[25:21];
        wr_entry.rt            = in_instr[20:16];
        wr_entry.imm           = {{16{in_instr[15]}}, in_instr[15:0]};
        wr_entry.pc            = in_pc;
        wr_entry.illegal       = illegal;
    end

    // Jumps carry no register sources, so they never wait on a load.
    assign is_jump   = (opcode == 6'h02) || (opcode == 6'h03);
    assign src_match = (in_instr[25:21] == ld_rd) || (in_instr[20:16] == ld_rd);
    assign is_lw     = (opcode == 6'h23) && (in_instr[20:16] != 5'd0) && !illegal;
    assign stall_now = armed && in_valid && !stall_done && !is_jump && src_match;

    assign in_ready  = !rst && !flush && (count < CW'(DEPTH)) && !stall_now;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Queue storage and pointers; flush empties the queue and drops any pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Load-use tracker: remembers the last pushed LW target for one slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed      <= 1'b0;
            ld_rd      <= 5'd0;
            stall_done <= 1'b0;
        end else if (flush) begin
            armed      <= 1'b0;
            stall_done <= 1'b0;
        end else if (push) begin
            armed      <= is_lw;
            ld_rd      <= is_lw ? in_instr[20:16] : ld_rd;
            stall_done <= 1'b0;
        end else if (stall_now) begin
            stall_done <= 1'b1;
        end
    end

    // Saturating count of bubble cycles; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_now && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign head              = mem[rd_ptr];
    assign out_Af            = head.af;
    assign out_Bf            = head.bf;
    assign out_I             = head.imm_sel;
    assign out_ALU_MUX_SEL   = head.alu_mux_sel;
    assign out_GP_WE         = head.gp_we;
    assign out_DM_WE         = head.dm_we;
    assign out_Cad           = head.cad;
    assign out_GP_MUX_SEL    = head.gp_mux_sel;
    assign out_Shift_type    = head.shift_type;
    assign out_PC_MUX_Select = head.pc_mux_select;
    assign out_rs            = head.rs;
    assign out_rt            = head.rt;
    assign out_imm           = head.imm;
    assign out_pc            = head.pc;
    assign out_illegal       = head.illegal;
endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage with a queue scoreboard of expected
// decoded entries; build with DEC_ILLEGAL_TRAP_EN to exercise the trap.
module tb_inst_decode_stage;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int DEPTH = 2;
`ifdef DEC_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    localparam logic [31:0] ADD1 = 32'h00852020;
    localparam logic [31:0] LW1  = 32'h8C850004;
    localparam logic [31:0] ADD2 = 32'h00A53020;
    localparam logic [31:0] JMP  = 32'h08000009;
    localparam logic [31:0] LWN  = 32'h8C85FFFC;
    localparam logic [31:0] LW0  = 32'h8C800004;
    localparam logic [31:0] ADD0 = 32'h00003820;
    localparam logic [31:0] SW1  = 32'hACA50008;
    localparam logic [31:0] ILL  = 32'hFC000000;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_Af;
    logic [3:0]       out_Bf;
    logic             out_I;
    logic             out_ALU_MUX_SEL;
    logic             out_GP_WE;
    logic             out_DM_WE;
    logic [4:0]       out_Cad;
    logic [1:0]       out_GP_MUX_SEL;
    logic [2:0]       out_Shift_type;
    logic [1:0]       out_PC_MUX_Select;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [31:0]      out_imm;
    logic [PC_W-1:0]  out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] stall_count;

    inst_decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_Af            (out_Af),
        .out_Bf            (out_Bf),
        .out_I             (out_I),
        .out_ALU_MUX_SEL   (out_ALU_MUX_SEL),
        .out_GP_WE         (out_GP_WE),
        .out_DM_WE         (out_DM_WE),
        .out_Cad           (out_Cad),
        .out_GP_MUX_SEL    (out_GP_MUX_SEL),
        .out_Shift_type    (out_Shift_type),
        .out_PC_MUX_Select (out_PC_MUX_Select),
        .out_rs            (out_rs),
        .out_rt            (out_rt),
        .out_imm           (out_imm),
        .out_pc            (out_pc),
        .out_illegal       (out_illegal),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic [4:0]  cad;
        logic [3:0]  af;
        logic [1:0]  pcmux;
        logic        gp_we;
        logic        dm_we;
        logic        ill;
    } exp_t;

    exp_t             sb[$];
    exp_t             pend;
    int               passed = 0;
    int               total  = 0;
    logic             s_in_ready;
    logic             s_out_valid;
    logic [PC_W-1:0]  s_out_pc;
    logic [CNT_W-1:0] s_stall_count;

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [4:0] cad, input logic [3:0] af,
                                input logic [1:0] pcmux, input logic gp_we,
                                input logic dm_we, input logic ill);
        exp_t e;
        e.pc    = pc;
        e.rs    = ins[25:21];
        e.rt    = ins[20:16];
        e.imm   = {{16{ins[15]}}, ins[15:0]};
        e.cad   = cad;
        e.af    = af;
        e.pcmux = pcmux;
        e.gp_we = gp_we;
        e.dm_we = dm_we;
        e.ill   = ill;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        pend     = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc    = '0;
    endtask

    // One cycle: sample at the falling edge, update scoreboard, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_in_ready    = in_ready;
        s_out_valid   = out_valid;
        s_out_pc      = out_pc;
        s_stall_count = stall_count;
        if (flush) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back(pend);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("output_without_expected_entry", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_rs", 32'(out_rs), 32'(e.rs));
                    check("out_rt", 32'(out_rt), 32'(e.rt));
                    check("out_imm", out_imm, e.imm);
                    check("out_Cad", 32'(out_Cad), 32'(e.cad));
                    check("out_Af", 32'(out_Af), 32'(e.af));
                    check("out_PC_MUX_Select", 32'(out_PC_MUX_Select), 32'(e.pcmux));
                    check("out_GP_WE", 32'(out_GP_WE), 32'(e.gp_we));
                    check("out_DM_WE", 32'(out_DM_WE), 32'(e.dm_we));
                    check("out_illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        pend = mk(32'h0, 32'h0, 5'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_stall_count", 32'(stall_count), 32'd0);
        check("reset_out_pc", out_pc, 32'd0);
        check("reset_out_GP_WE", 32'(out_GP_WE), 32'd0);
        rst = 1'b0;

        // Decode and one-cycle latency.
        out_ready = 1'b1;
        drive(ADD1, 32'h100, mk(ADD1, 32'h100, 5'd4, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("add_in_ready", 32'(s_in_ready), 32'd1);
        idle();
        tick();
        check("add_latency_out_valid", 32'(s_out_valid), 32'd1);

        // Load-use: exactly one bubble.
        drive(LW1, 32'h104, mk(LW1, 32'h104, 5'd5, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("lw_in_ready", 32'(s_in_ready), 32'd1);
        drive(ADD2, 32'h108, mk(ADD2, 32'h108, 5'd6, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("hazard_stall_in_ready", 32'(s_in_ready), 32'd0);
        tick();
        check("hazard_retry_in_ready", 32'(s_in_ready), 32'd1);
        check("hazard_stall_count", 32'(s_stall_count), 32'd1);
        idle();
        tick();
        check("hazard_dep_out_valid", 32'(s_out_valid), 32'd1);

        // No false stalls: jump after LW, and LW to $0.
        drive(LWN, 32'h200, mk(LWN, 32'h200, 5'd5, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(JMP, 32'h204, mk(JMP, 32'h204, 5'd0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0));
        tick();
        check("jump_no_stall", 32'(s_in_ready), 32'd1);
        drive(LW0, 32'h208, mk(LW0, 32'h208, 5'd0, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(ADD0, 32'h20C, mk(ADD0, 32'h20C, 5'd7, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("reg0_no_stall", 32'(s_in_ready), 32'd1);
        idle();
        tick();
        check("no_false_stall_count", 32'(s_stall_count), 32'd1);

        // Backpressure with a full queue.
        out_ready = 1'b0;
        drive(ADD1, 32'h300, mk(ADD1, 32'h300, 5'd4, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(SW1, 32'h304, mk(SW1, 32'h304, 5'd0, 4'h1, 2'd0, 1'b0, 1'b1, 1'b0));
        tick();
        check("bp_second_push", 32'(s_in_ready), 32'd1);
        drive(ADD1, 32'h308, mk(ADD1, 32'h308, 5'd4, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("bp_full_in_ready", 32'(s_in_ready), 32'd0);
        check("bp_head_pc", s_out_pc, 32'h300);
        tick();
        check("bp_full_in_ready_hold", 32'(s_in_ready), 32'd0);
        check("bp_head_stable", s_out_pc, 32'h300);
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_drained_out_valid", 32'(s_out_valid), 32'd0);

        // Flush a full queue with a pending LW hazard.
        out_ready = 1'b0;
        drive(ADD1, 32'h3F0, mk(ADD1, 32'h3F0, 5'd4, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(LW1, 32'h400, mk(LW1, 32'h400, 5'd5, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        idle();
        flush = 1'b1;
        tick();
        check("flush_in_ready", 32'(s_in_ready), 32'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(ADD2, 32'h410, mk(ADD2, 32'h410, 5'd6, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("flush_out_valid", 32'(s_out_valid), 32'd0);
        check("flush_no_stall", 32'(s_in_ready), 32'd1);
        idle();
        tick();
        check("flush_keeps_stall_count", 32'(s_stall_count), 32'd1);

        // Undefined opcode 0x3F.
        drive(ILL, 32'h500, mk(ILL, 32'h500, 5'd0, 4'h0, 2'd0, 1'b0, 1'b0, TRAP));
        tick();
        idle();
        tick();
        check("illegal_out_valid", 32'(s_out_valid), 32'd1);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        drive(LW1, 32'h600, mk(LW1, 32'h600, 5'd5, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(ADD2, 32'h604, mk(ADD2, 32'h604, 5'd6, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check("second_stall_in_ready", 32'(s_in_ready), 32'd0);
        check("second_stall_count", 32'(stall_count), 32'd2);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_stall_count", 32'(stall_count), 32'd0);
        check("async_rst_out_pc", out_pc, 32'd0);
        check("async_rst_out_Cad", 32'(out_Cad), 32'd0);
        check("async_rst_out_GP_WE", 32'(out_GP_WE), 32'd0);
        sb.delete();
        idle();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", 32'(s_out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered, handshaked instruction-decode pipeline stage that wraps the existing combinational `Inst_Decoder`. It adds an elastic output queue of parameterised depth and a load-use hazard interlock that inserts one stall cycle. It also adds a saturating stall counter and pipeline flush. The block sits between instruction fetch and the execute stage of the MIPS-subset core.

## Interface
- `DEPTH`, 2: output queue entries; power of two, ≥2.
- `PC_W`, 32: program-counter width.
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: discard queue contents and hazard state.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in PC_W: instruction address.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: execute consumes the head.
- `out_Af`, `out_Bf` out 4: ALU/branch function codes, as produced by `Inst_Decoder`.
- `out_I`, `out_ALU_MUX_SEL`, `out_GP_WE`, `out_DM_WE` out 1: decoder control bits.
- `out_Cad` out 5, `out_GP_MUX_SEL` out 2, `out_Shift_type` out 3, `out_PC_MUX_Select` out 2: decoder fields.
- `out_rs`, `out_rt` out 5: instr[25:21], instr[20:16].
- `out_imm` out 32: sign-extended instr[15:0].
- `out_pc` out PC_W: captured PC.
- `out_illegal` out 1: undefined encoding (see Configuration).
- `stall_count` out CNT_W: saturating count of hazard-stall cycles.

## Operation
- **Accept:**
  - A push occurs when `in_valid && in_ready`.
  - `Inst_Decoder` is driven from `in_instr` combinationally.
  - Its outputs plus rs/rt/imm/pc/illegal are written as one entry at the queue tail.
- **Release:**
  - A pop occurs when `out_valid && out_ready`.
  - `out_*` always show the head entry.
  - `out_valid = (count != 0)`.
- **Readiness:**
  - `in_ready = !rst && !flush && (count < DEPTH) && !stall_now`.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - A full queue does not accept, even if popping that cycle.
- **Hazard tracking:**
  - On every push, `armed` is updated.
  - `armed` ← 1 and `ld_rd` ← instr[20:16] if opcode = 100011 (LW) and instr[20:16] ≠ 0.
  - Otherwise `armed` ← 0.
- **Stall:**
  - `stall_now = armed && in_valid && !stall_done && opcode ∉ {000010, 000011} && (instr[25:21] == ld_rd || instr[20:16] == ld_rd)`.
  - A stall cycle sets `stall_done`.
  - On the next cycle the same instruction is accepted normally, and that push clears `stall_done`.
  - Exactly one bubble is inserted per matching pair.
  - `stall_count` increments by 1 per stall cycle and saturates at 2^CNT_W−1.
- **Flush:**
  - Same-cycle pop is ignored.
  - Count is set to 0.
  - `armed` and `stall_done` are cleared.
  - No push occurs.
  - `stall_count` is kept.
- **Register 0:** never a hazard source (guaranteed by the `ld_rd ≠ 0` arm condition).

## Timing
- **Latency:** an instruction pushed in cycle N is visible with `out_valid` = 1 in cycle N+1, when the queue was empty.
- **Throughput:** one instruction per cycle with DEPTH ≥ 2 and `out_ready` held high.
- **Load-use pair:** LW pushed at N; dependent instruction sees `in_ready` = 0 at N+1 and is pushed at N+2.
- **Reset:**
  - Reset is asynchronous; all state clears immediately on `rst` rise.
  - `count`, `armed`, `stall_done`, `stall_count` = 0.
  - All `out_*` = 0, `out_valid` = 0, `in_ready` = 0.
  - First push is possible on the first edge after `rst` falls.
  - A reset mid-stall or with a full queue loses all entries without producing a partial output.
- **Pointers:** wrap modulo DEPTH with no extra bit; an explicit count register (log2(DEPTH)+1 bits) disambiguates full from empty.
- **Head stability:** `out_*` hold stable while `out_valid && !out_ready`.

## Configuration
- **`DEC_ILLEGAL_TRAP_EN` defined:**
  - `out_illegal` = 1 for any encoding outside the legal set:
    - opcode 000000 with funct ∈ {00, 02, 03, 04, 06, 07, 08, 09, 20–27, 2A, 2B} hex;
    - opcode 000001 with rt ∈ {0, 1};
    - opcodes 02–0F, 23, 2B hex.
  - Illegal entries are stored with `out_GP_WE` = 0 and `out_DM_WE` = 0.
  - Illegal entries never arm the hazard tracker.
- **`DEC_ILLEGAL_TRAP_EN` undefined:** `out_illegal` is tied to 0; decoder outputs pass unmodified.

## Test plan
- **Decode and latency:** reset, then push ADD 0x00852020 with `out_ready` = 1 → next cycle `out_valid` = 1, `out_rs` = 4, `out_rt` = 5, `out_pc` = pushed PC, fields equal `Inst_Decoder` output.
- **Load-use stall:** push LW 0x8C850004 then ADD 0x00A53020 back-to-back → `in_ready` = 0 for exactly one cycle, ADD emerges two cycles after LW, `stall_count` = 1.
- **No false stall:** LW writing $5 followed by J 0x08000009, and LW writing $0 followed by ADD reading $0 → no stall cycles.
- **Backpressure:** hold `out_ready` = 0 and push 3 instructions with DEPTH = 2 → `in_ready` = 0 after 2 pushes, head stable; release → both drain in order.
- **Flush:** queue full, assert `flush` one cycle → `out_valid` = 0 next cycle; a pending LW hazard is cleared and the following dependent instruction is accepted without a stall.
- **Illegal and reset:**
  - With `DEC_ILLEGAL_TRAP_EN`, push opcode 0x3F → `out_illegal` = 1, `out_GP_WE` = 0.
  - Assert `rst` mid-stall → all outputs 0 immediately.
